// File: rtl/pl_run_ctrl_if.sv
// Debug-button / CPU-side signal bundle for the pl_run_ctrl run/step/breakpoint sequencer.
// stall_cnt exists only when RUN_CTRL_STALL_CNT_EN is defined.
interface pl_run_ctrl_if #(
    parameter int CNT_W = 32
);
    // Requests are single-cycle pulses with no ready: the controller samples them
    // on every rising edge and silently drops any request its current state ignores.
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic             brk_en;
    logic [31:0]      brk_pc;
    logic [31:0]      pc_f;
    logic             fstall;
    logic             cpu_en;
    logic [1:0]       state;
    logic             brk_hit;
    logic             step_done;
    logic [CNT_W-1:0] cyc_cnt;
`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    modport master (
        output run_req, step_req, halt_req, brk_en, brk_pc, pc_f, fstall,
        input  cpu_en, state, brk_hit, step_done, cyc_cnt
`ifdef RUN_CTRL_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  run_req, step_req, halt_req, brk_en, brk_pc, pc_f, fstall,
        output cpu_en, state, brk_hit, step_done, cyc_cnt
`ifdef RUN_CTRL_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/pl_run_ctrl.sv
// Run/step/breakpoint sequencer producing the pipelined CPU clock-enable and a cycle counter.
// Optional stall counter output enabled by defining RUN_CTRL_STALL_CNT_EN.
module pl_run_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    pl_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_skip;
    logic [31:0]      r_skip_pc;
    logic             r_brk_hit;
    logic             r_step_done;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic             w_brk_match;
    logic             w_cpu_en;
    logic             w_resume;
    logic             w_brk_stop;
    logic             w_step_end;

    // skip masks the breakpoint until the fetch PC moves off the address we resumed from
    assign w_brk_match = bus.brk_en & (bus.pc_f == bus.brk_pc) & ~r_skip;
    assign w_cpu_en    = ((r_state == S_RUN) & ~w_brk_match) | (r_state == S_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_resume    = 1'b0;
        w_brk_stop  = 1'b0;
        w_step_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.halt_req)      w_state_nxt = S_IDLE;
                else if (bus.step_req) w_state_nxt = S_STEP;
                else if (bus.run_req)  w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (w_brk_match) begin
                    w_state_nxt = S_HALT;
                    w_brk_stop  = 1'b1;
                end
            end
            S_STEP: begin
                w_state_nxt = S_HALT;
                w_step_end  = 1'b1;
            end
            S_HALT: begin
                if (bus.halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (bus.step_req) begin
                    w_state_nxt = S_STEP;
                end else if (bus.run_req) begin
                    w_state_nxt = S_RUN;
                    w_resume    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skip      <= 1'b0;
            r_skip_pc   <= 32'h0;
            r_brk_hit   <= 1'b0;
            r_step_done <= 1'b0;
            r_cyc_cnt   <= '0;
        end else begin
            r_brk_hit   <= w_brk_stop;
            r_step_done <= w_step_end;
            // a fetch stall holds pc_f, which by itself keeps skip set
            if (w_resume) begin
                r_skip    <= 1'b1;
                r_skip_pc <= bus.pc_f;
            end else if (r_skip && (bus.pc_f != r_skip_pc)) begin
                r_skip <= 1'b0;
            end
            if (w_cpu_en && (r_cyc_cnt != '1)) r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
        end
    end

`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                                     r_stall_cnt <= '0;
        else if (w_cpu_en && bus.fstall && (r_stall_cnt != '1))       r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.cpu_en    = w_cpu_en;
    assign bus.state     = r_state;
    assign bus.brk_hit   = r_brk_hit;
    assign bus.step_done = r_step_done;
    assign bus.cyc_cnt   = r_cyc_cnt;
endmodule

// File: tb/tb_pl_run_ctrl.sv
// Directed bench for pl_run_ctrl: reset, run/halt, stepping, breakpoints, skip, priority, saturation.
module tb_pl_run_ctrl;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   en_cnt;
  int   hit_cnt;
  int   done_cnt;
  int   both_cnt;

  pl_run_ctrl_if #(.CNT_W(32)) bus ();
  pl_run_ctrl_if #(.CNT_W(4))  sbus ();

  pl_run_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  pl_run_ctrl #(.CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  // the narrow-counter instance sees exactly the same stimulus
  assign sbus.run_req  = bus.run_req;
  assign sbus.step_req = bus.step_req;
  assign sbus.halt_req = bus.halt_req;
  assign sbus.brk_en   = bus.brk_en;
  assign sbus.brk_pc   = bus.brk_pc;
  assign sbus.pc_f     = bus.pc_f;
  assign sbus.fstall   = bus.fstall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    en_cnt = 0; hit_cnt = 0; done_cnt = 0; both_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.cpu_en === 1'b1) en_cnt++;
    if (bus.brk_hit === 1'b1) hit_cnt++;
    if (bus.step_done === 1'b1) done_cnt++;
    if (bus.brk_hit === 1'b1 && bus.step_done === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one cycle of a CPU whose fetch PC advances by 4 whenever it is enabled
  task automatic cpu_cyc();
    logic en;
    #1;
    en = bus.cpu_en;
    @(posedge clk);
    #1;
    if (en) bus.pc_f = bus.pc_f + 32'd4;
  endtask

  initial begin
    int b_en;
    int b_hit;
    int b_done;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0;
    bus.brk_en = 0; bus.brk_pc = 32'h0; bus.pc_f = 32'h0; bus.fstall = 0;
    repeat (2) cyc();
    check("rst_state", 32'(bus.state), 0);
    check("rst_cpu_en", 32'(bus.cpu_en), 0);
    check("rst_brk_hit", 32'(bus.brk_hit), 0);
    check("rst_step_done", 32'(bus.step_done), 0);
    check("rst_cyc_cnt", bus.cyc_cnt, 0);

    rst = 1'b1;
    repeat (5) cyc();
    check("idle_state", 32'(bus.state), 0);
    check("idle_cpu_en", 32'(bus.cpu_en), 0);
    check("idle_cyc_cnt", bus.cyc_cnt, 0);

    // free run for 10 enabled cycles, then halt
    b_en = en_cnt;
    bus.run_req = 1; cyc(); bus.run_req = 0;
    check("run_state", 32'(bus.state), 1);
    check("run_cpu_en", 32'(bus.cpu_en), 1);
    repeat (9) cyc();
    bus.halt_req = 1; cyc(); bus.halt_req = 0;
    check("halt_state", 32'(bus.state), 3);
    check("halt_cpu_en", 32'(bus.cpu_en), 0);
    check("halt_cyc_cnt", bus.cyc_cnt, 10);
    check("run_en_cycles", 32'(en_cnt - b_en), 10);
    check("sat_cyc_cnt_10", 32'(sbus.cyc_cnt), 10);

    // three single steps from HALT, spaced 4 cycles apart
    b_en = en_cnt; b_done = done_cnt;
    for (int k = 0; k < 3; k++) begin
      bus.step_req = 1; cyc(); bus.step_req = 0;
      check("step_state", 32'(bus.state), 2);
      check("step_cpu_en", 32'(bus.cpu_en), 1);
      cyc();
      check("step_back_halt", 32'(bus.state), 3);
      check("step_done_pulse", 32'(bus.step_done), 1);
      check("step_after_en", 32'(bus.cpu_en), 0);
      cyc();
      check("step_done_clear", 32'(bus.step_done), 0);
      cyc();
    end
    check("step_cyc_cnt", bus.cyc_cnt, 13);
    check("step_en_cycles", 32'(en_cnt - b_en), 3);
    check("step_done_count", 32'(done_cnt - b_done), 3);

    // breakpoint at 0x3010, CPU fetching from 0x3000
    bus.brk_en = 1; bus.brk_pc = 32'h3010; bus.pc_f = 32'h3000;
    b_hit = hit_cnt;
    bus.run_req = 1; cpu_cyc(); bus.run_req = 0;
    for (int i = 0; i < 16 && bus.pc_f != 32'h3010; i++) cpu_cyc();
    check("brk_pc_reached", bus.pc_f, 32'h3010);
    #1;
    check("brk_cpu_en", 32'(bus.cpu_en), 0);
    check("brk_match_state", 32'(bus.state), 1);
    cyc();
    check("brk_halt_state", 32'(bus.state), 3);
    check("brk_hit_pulse", 32'(bus.brk_hit), 1);
    check("brk_cyc_cnt", bus.cyc_cnt, 17);
    check("sat_cyc_cnt_max", 32'(sbus.cyc_cnt), 15);
    cyc();
    check("brk_hit_clear", 32'(bus.brk_hit), 0);
    check("brk_hit_count", 32'(hit_cnt - b_hit), 1);

    // resume sitting on the breakpoint address; a held PC keeps the skip active
    bus.run_req = 1; cyc(); bus.run_req = 0;
    check("resume_state", 32'(bus.state), 1);
    check("resume_cpu_en", 32'(bus.cpu_en), 1);
    bus.fstall = 1; cyc();
    check("skip_hold_cpu_en", 32'(bus.cpu_en), 1);
    check("skip_hold_state", 32'(bus.state), 1);
    bus.fstall = 0; bus.pc_f = 32'h3014; cyc();
    bus.pc_f = 32'h3010; #1;
    check("rebreak_cpu_en", 32'(bus.cpu_en), 0);
    cyc();
    check("rebreak_state", 32'(bus.state), 3);
    check("rebreak_hit", 32'(bus.brk_hit), 1);
    check("rebreak_cyc_cnt", bus.cyc_cnt, 19);

    // step beats run when both arrive in HALT
    bus.brk_en = 0;
    bus.run_req = 1; bus.step_req = 1; cyc(); bus.run_req = 0; bus.step_req = 0;
    check("prio_step_state", 32'(bus.state), 2);
    cyc();
    check("prio_halt_state", 32'(bus.state), 3);
    check("prio_cyc_cnt", bus.cyc_cnt, 20);
    bus.halt_req = 1; cyc(); bus.halt_req = 0;
    check("halt_in_halt", 32'(bus.state), 3);

    // asynchronous reset in the middle of a run
    bus.run_req = 1; cyc(); bus.run_req = 0;
    repeat (3) cyc();
    check("prerst_cyc_cnt", bus.cyc_cnt, 23);
    rst = 1'b0; #1;
    check("async_rst_cpu_en", 32'(bus.cpu_en), 0);
    check("async_rst_cyc_cnt", bus.cyc_cnt, 0);
    check("async_rst_state", 32'(bus.state), 0);
    check("async_rst_sat_cnt", 32'(sbus.cyc_cnt), 0);
    cyc();
    rst = 1'b1;
    cyc();

    // all three requests at once in IDLE: halt wins and is ignored
    bus.run_req = 1; bus.step_req = 1; bus.halt_req = 1; cyc();
    bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0;
    check("all_req_state", 32'(bus.state), 0);
    check("all_req_cpu_en", 32'(bus.cpu_en), 0);

    // halt during the step cycle still completes the step
    bus.step_req = 1; cyc(); bus.step_req = 0;
    check("idle_step_state", 32'(bus.state), 2);
    bus.halt_req = 1; cyc(); bus.halt_req = 0;
    check("step_halt_state", 32'(bus.state), 3);
    check("step_halt_done", 32'(bus.step_done), 1);
    check("step_halt_cyc_cnt", bus.cyc_cnt, 1);
    check("no_hit_and_done", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
